// File: rtl/many_digit_bcd_counter_pkg.sv
// Shared rate-select encoding and seven-segment patterns for many_digit_bcd_counter.
// Segment vectors are ordered {a,b,c,d,e,f,g}, active high.
package many_digit_pkg;

  typedef enum logic [1:0] {
    RATE_SLOW   = 2'd0,
    RATE_MEDIUM = 2'd1,
    RATE_HIGH   = 2'd2,
    RATE_FAST   = 2'd3
  } rate_e;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Codes above 9 never occur in a healthy counter; show them blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/many_digit_bcd_counter_bcd_digit.sv
// One BCD up/down digit cell; carry_out ripples combinationally into the next cell.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_en,
  input  logic       up_down,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] value_r;
  logic [3:0] next_s;

  // Next digit value and ripple carry/borrow for this cell
  always_comb begin
    next_s    = value_r;
    carry_out = 1'b0;
    if (inc_en) begin
      if (up_down) begin
        if (value_r >= 4'd9) begin
          next_s    = 4'd0;
          carry_out = 1'b1;
        end else begin
          next_s = value_r + 4'd1;
        end
      end else begin
        if (value_r == 4'd0) begin
          next_s    = 4'd9;
          carry_out = 1'b1;
        end else if (value_r > 4'd9) begin
          next_s = 4'd9;
        end else begin
          next_s = value_r - 4'd1;
        end
      end
    end else begin
      next_s = value_r;
    end
  end

  // Digit storage
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= 4'd0;
    end else begin
      value_r <= next_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/many_digit_bcd_counter_checker.sv
// Elaboration-time parameter legality checks for many_digit_bcd_counter.
module many_digit_bcd_counter_checker #(
  parameter int DIGITS    = 4,
  parameter int DIV_WIDTH = 26,
  parameter int DIV0      = 50_000_000,
  parameter int DIV1      = 25_000_000,
  parameter int DIV2      = 5_000_000,
  parameter int DIV3      = 500_000,
  parameter int SCAN_DIV  = 50_000
) ();

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("many_digit_bcd_counter: DIGITS must be in 1..8");
  end

  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_bad_div
    $error("many_digit_bcd_counter: every DIVn must be at least 2");
  end

  if ($clog2(DIV0) > DIV_WIDTH || $clog2(DIV1) > DIV_WIDTH ||
      $clog2(DIV2) > DIV_WIDTH || $clog2(DIV3) > DIV_WIDTH) begin : g_bad_width
    $error("many_digit_bcd_counter: DIVn-1 does not fit in DIV_WIDTH");
  end

  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("many_digit_bcd_counter: SCAN_DIV must be at least 1");
  end

endmodule

// File: rtl/many_digit_bcd_counter.sv
// Multi-digit BCD up/down counter with selectable tick rate and scanned seven-segment drive.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module many_digit_bcd_counter
  import many_digit_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV_WIDTH = 26,
  parameter int DIV0      = 50_000_000,
  parameter int DIV1      = 25_000_000,
  parameter int DIV2      = 5_000_000,
  parameter int DIV3      = 500_000,
  parameter int SCAN_DIV  = 50_000
) (
  input  logic                fpga_clock,
  input  logic                reset,
  input  logic [1:0]          select,
  input  logic                enable,
  input  logic                up_down,
  output logic                filtered_clock,
  output logic                wrap,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   an,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                e,
  output logic                f,
  output logic                g
);

  localparam logic [DIV_WIDTH-1:0] TERM0 = DIV_WIDTH'(DIV0 - 1);
  localparam logic [DIV_WIDTH-1:0] TERM1 = DIV_WIDTH'(DIV1 - 1);
  localparam logic [DIV_WIDTH-1:0] TERM2 = DIV_WIDTH'(DIV2 - 1);
  localparam logic [DIV_WIDTH-1:0] TERM3 = DIV_WIDTH'(DIV3 - 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  many_digit_bcd_counter_checker #(
    .DIGITS(DIGITS), .DIV_WIDTH(DIV_WIDTH), .DIV0(DIV0), .DIV1(DIV1),
    .DIV2(DIV2), .DIV3(DIV3), .SCAN_DIV(SCAN_DIV)
  ) u_checker ();

  rate_e                 sel_r;
  rate_e                 sel_prev_r;
  logic [DIV_WIDTH-1:0]  div_r;
  logic [DIV_WIDTH-1:0]  term_s;
  logic                  sel_change_s;
  logic                  tick_s;
  logic                  filtered_clock_r;
  logic                  wrap_r;
  logic [DIGITS:0]       carry_s;
  logic [3:0]            digit_s [DIGITS];
  logic [DIGITS-1:0]     blank_s;
  logic [SCAN_W-1:0]     scan_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DIGITS-1:0]     an_s;
  logic [DIGITS-1:0]     an_r;
  logic [6:0]            seg_s;
  logic [6:0]            seg_r;

  // Terminal divider count for the registered rate
  always_comb begin
    case (sel_r)
      RATE_SLOW:   term_s = TERM0;
      RATE_MEDIUM: term_s = TERM1;
      RATE_HIGH:   term_s = TERM2;
      RATE_FAST:   term_s = TERM3;
      default:     term_s = TERM0;
    endcase
  end

  // A rate change restarts the period from zero and swallows that cycle's tick.
  assign sel_change_s = (sel_r != sel_prev_r);
  assign tick_s       = ~sel_change_s & (div_r >= term_s);

  // Rate select pipeline, divider and LED square wave
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      sel_r            <= RATE_SLOW;
      sel_prev_r       <= RATE_SLOW;
      div_r            <= '0;
      filtered_clock_r <= 1'b0;
    end else begin
      sel_r      <= rate_e'(select);
      sel_prev_r <= sel_r;
      if (sel_change_s || tick_s) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + DIV_WIDTH'(1);
      end
      if (tick_s) begin
        filtered_clock_r <= ~filtered_clock_r;
      end else begin
        filtered_clock_r <= filtered_clock_r;
      end
    end
  end

  assign carry_s[0] = tick_s & enable;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (fpga_clock),
      .reset     (reset),
      .inc_en    (carry_s[i]),
      .up_down   (up_down),
      .value     (digit_s[i]),
      .carry_out (carry_s[i+1])
    );
    assign bcd[4*i +: 4] = digit_s[i];
  end

  // Full-counter wrap pulse, aligned with the bcd update
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= carry_s[DIGITS];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks while it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic lz;
    blank_s = '0;
    lz      = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz         = lz & (digit_s[i] == 4'd0);
      blank_s[i] = lz;
    end
  end
`else
  assign blank_s = '0;
`endif

  // Anode and segment values for the digit currently being scanned
  always_comb begin
    an_s = DIGITS'(1) << idx_r;
    if (blank_s[idx_r]) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_decode(digit_s[idx_r]);
    end
  end

  // Scan timing and registered display drive
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
      an_r       <= DIGITS'(1);
      seg_r      <= SEG_0;
    end else begin
      if (scan_cnt_r == SCAN_LAST) begin
        scan_cnt_r <= '0;
        idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign filtered_clock      = filtered_clock_r;
  assign wrap                = wrap_r;
  assign an                  = an_r;
  assign {a, b, c, d, e, f, g} = seg_r;

endmodule
